log2_pow2_unit: RTL and testbench

//  Mitchell-style piecewise-linear log2 / 2^x approximator; mode input selects the function.

---
 rtl/log2_pow2_unit_if.sv | 21 ++
 rtl/log2_pow2_unit.sv | 81 ++++++++
 tb/tb_log2_pow2_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/log2_pow2_unit_if.sv
// Handshake/data bundle for log2_pow2_unit; out_err exists only when L2P2_ERR_FLAG_EN is defined.
interface log2_pow2_unit_if;
  logic        in_valid;
  logic        mode;
  logic [15:0] in_x;
  logic        out_valid;
  logic [15:0] out_y;
`ifdef L2P2_ERR_FLAG_EN
  logic        out_err;

  modport master (output in_valid, output mode, output in_x,
                  input  out_valid, input out_y, input out_err);
  modport slave  (input  in_valid, input mode, input in_x,
                  output out_valid, output out_y, output out_err);
`else
  modport master (output in_valid, output mode, output in_x,
                  input  out_valid, input out_y);
  modport slave  (input  in_valid, input mode, input in_x,
                  output out_valid, output out_y);
`endif
endinterface

// File: rtl/log2_pow2_unit.sv
// Mitchell piecewise-linear log2 / 2^x on Q-format 16-bit data, one registered stage.
// Optional saturation flag output enabled by defining L2P2_ERR_FLAG_EN.
module log2_pow2_unit (
  input  logic             clk,
  input  logic             rst,
  log2_pow2_unit_if.slave  bus
);

  logic [3:0]  w_k;
  logic [3:0]  w_log_int;
  logic [11:0] w_frac;
  logic [15:0] w_log_val;
  logic        w_log_sat;

  logic [3:0]  w_n;
  logic [3:0]  w_neg_sh;
  logic [15:0] w_pow_neg;
  logic [15:0] w_pow_pos;
  logic [15:0] w_pow_val;
  logic        w_pow_sat;

  logic [15:0] w_y;

  logic        r_valid;
  logic [15:0] r_y;

  // Leading-one position; later iterations win so the highest set bit is kept.
  always_comb begin
    w_k = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (bus.in_x[i]) w_k = 4'(i);
    end
  end

  // Shifting x*4096 right by k lands the leading one on bit 12, leaving the mantissa below it.
  assign w_frac    = 12'({bus.in_x, 12'b0} >> w_k);
  assign w_log_int = w_k - 4'd12;
  assign w_log_val = {w_log_int, w_frac};
  assign w_log_sat = (bus.in_x < 16'h0010);

  assign w_n       = bus.in_x[15:12];
  assign w_neg_sh  = ~w_n + 4'd1;
  assign w_pow_neg = 16'({4'b0001, bus.in_x[11:0]} >> w_neg_sh);
  assign w_pow_pos = 16'({4'b0001, bus.in_x[11:0]} << w_n[1:0]);
  assign w_pow_val = w_n[3] ? w_pow_neg : w_pow_pos;
  assign w_pow_sat = !w_n[3] && (w_n[2:0] >= 3'd3);

  assign w_y = bus.mode ? (w_pow_sat ? 16'h7FFF : w_pow_val)
                        : (w_log_sat ? 16'h8000 : w_log_val);

`ifdef L2P2_ERR_FLAG_EN
  logic r_err;
  logic w_sat;

  assign w_sat = bus.mode ? w_pow_sat : w_log_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (bus.in_valid) begin
      r_err <= w_sat;
    end
  end

  assign bus.out_err = r_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_y     <= 16'h0000;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) r_y <= w_y;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_y     = r_y;

endmodule

// File: tb/tb_log2_pow2_unit.sv
// Self-checking bench for log2_pow2_unit: directed vectors, randomized sweep, timing and reset.
module tb_log2_pow2_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  logic [15:0] last_y;
  logic        last_err;

  log2_pow2_unit_if bus();

  log2_pow2_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_log2(input logic [15:0] x);
    int k, frac, res;
    if (x < 16'd16) return 16'h8000;
    k    = $clog2(int'(x) + 1) - 1;
    frac = ((int'(x) - (1 << k)) * 4096) / (1 << k);
    res  = (k - 12) * 4096 + frac;
    return 16'(res);
  endfunction

  function automatic logic [15:0] ref_pow2(input logic [15:0] x);
    int n, f;
    logic [3:0] hi;
    hi = x[15:12];
    n  = (hi >= 4'd8) ? int'(hi) - 16 : int'(hi);
    f  = int'(x[11:0]);
    if (n >= 3) return 16'h7FFF;
    if (n >= 0) return 16'((4096 + f) * (1 << n));
    return 16'((4096 + f) / (1 << (-n)));
  endfunction

  function automatic logic ref_sat(input logic m, input logic [15:0] x);
    if (!m) return (x < 16'd16);
    return (x[15] == 1'b0) && (x[14:12] >= 3'd3);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] exp_y, input logic exp_err);
    chk({tag, ".valid"}, 16'(bus.out_valid), 16'd1);
    chk({tag, ".y"}, bus.out_y, exp_y);
`ifdef L2P2_ERR_FLAG_EN
    chk({tag, ".err"}, 16'(bus.out_err), 16'(exp_err));
`endif
    last_y   = exp_y;
    last_err = exp_err;
  endtask

  // One valid transaction: drive on negedge, sample 1 time unit after the next posedge.
  task automatic xact(input logic m, input logic [15:0] x, input logic [15:0] exp_y,
                      input logic exp_err, input string tag);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.in_x     = x;
    @(posedge clk);
    #1;
    check_out(tag, exp_y, exp_err);
    $display("xact %s mode=%0d x=%h y=%h", tag, m, x, bus.out_y);
  endtask

  task automatic model_xact(input logic m, input logic [15:0] x, input string tag);
    xact(m, x, m ? ref_pow2(x) : ref_log2(x), ref_sat(m, x), tag);
  endtask

  initial begin
    logic [15:0] rx;
    logic        rm;
    bus.in_valid = 1'b0;
    bus.mode     = 1'b0;
    bus.in_x     = 16'h0000;
    last_y       = 16'h0000;
    last_err     = 1'b0;

    #12;
    chk("rst.valid", 16'(bus.out_valid), 16'd0);
    chk("rst.y", bus.out_y, 16'h0000);
`ifdef L2P2_ERR_FLAG_EN
    chk("rst.err", 16'(bus.out_err), 16'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    xact(1'b0, 16'h0040, 16'hA000, 1'b0, "log_0040");
    xact(1'b0, 16'h00C0, 16'hB800, 1'b0, "log_00C0");
    xact(1'b0, 16'h1000, 16'h0000, 1'b0, "log_1000");
    xact(1'b0, 16'h5000, 16'h2400, 1'b0, "log_5000");
    xact(1'b0, 16'h0000, 16'h8000, 1'b1, "log_0000");
    xact(1'b0, 16'h000F, 16'h8000, 1'b1, "log_000F");
    xact(1'b0, 16'h0010, 16'h8000, 1'b0, "log_0010");
    xact(1'b0, 16'hFFFF, 16'h3FFF, 1'b0, "log_FFFF");
    xact(1'b1, 16'hC000, 16'h0100, 1'b0, "pow_C000");
    xact(1'b1, 16'hE400, 16'h0500, 1'b0, "pow_E400");
    xact(1'b1, 16'h0000, 16'h1000, 1'b0, "pow_0000");
    xact(1'b1, 16'h2E00, 16'h7800, 1'b0, "pow_2E00");
    xact(1'b1, 16'h3000, 16'h7FFF, 1'b1, "pow_3000");
    xact(1'b1, 16'h2FFF, 16'h7FFC, 1'b0, "pow_2FFF");
    xact(1'b1, 16'h8000, 16'h0010, 1'b0, "pow_8000");

    // Alternating mode, back-to-back valids.
    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom);
      model_xact(i[0], rx, $sformatf("b2b%0d", i));
    end

    // Gap: in_valid low must drop out_valid and hold out_y.
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mode     = ~bus.mode;
    bus.in_x     = ~bus.in_x;
    @(posedge clk);
    #1;
    chk("gap.valid", 16'(bus.out_valid), 16'd0);
    chk("gap.y", bus.out_y, last_y);
`ifdef L2P2_ERR_FLAG_EN
    chk("gap.err", 16'(bus.out_err), 16'(last_err));
`endif
    $display("gap y=%h", bus.out_y);

    for (int i = 0; i < 200; i++) begin
      rm = 1'($urandom);
      rx = 16'($urandom);
      if (i % 4 == 0) rx = rx >> ($urandom_range(15, 0));
      model_xact(rm, rx, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-stream, between clock edges.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mode     = 1'b1;
    bus.in_x     = 16'h1000;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.valid", 16'(bus.out_valid), 16'd0);
    chk("arst.y", bus.out_y, 16'h0000);
`ifdef L2P2_ERR_FLAG_EN
    chk("arst.err", 16'(bus.out_err), 16'd0);
`endif
    $display("arst y=%h valid=%0d", bus.out_y, bus.out_valid);
    @(posedge clk);
    #1;
    chk("arst_hold.valid", 16'(bus.out_valid), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    xact(1'b0, 16'h5000, 16'h2400, 1'b0, "post_rst");

    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
